clint_timer: RTL and testbench

//  Multi-hart machine timer (CLINT-style): one shared 64-bit mtime, one 64-bit mtimecmp per hart, per-hart timer IRQs.

---
 rtl/clint_pkg.sv | 32 +++
 rtl/clint_prescaler.sv | 36 +++
 rtl/clint_timer.sv | 140 ++++++++++++++
 tb/tb_clint_timer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/clint_pkg.sv
// -----------------------------------------------------------------------------
// clint_pkg
// Address map and shared types for the CLINT-style machine timer. This package
// is shared by clint_timer and the MMIO decoder that routes accesses to it.
// Contents:
//   CLINT_* localparams  byte addresses of the register windows
//   clint_time_t         64-bit mtime / mtimecmp value
//   msip_addr, cmp_lo_addr, cmp_hi_addr  per-hart register addresses
// -----------------------------------------------------------------------------
package clint_pkg;

    localparam logic [15:0] CLINT_MSIP_BASE     = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_BASE = 16'h4000;
    localparam logic [15:0] CLINT_DIV_ADDR      = 16'hBFF0;
    localparam logic [15:0] CLINT_MTIME_LO      = 16'hBFF8;
    localparam logic [15:0] CLINT_MTIME_HI      = 16'hBFFC;

    typedef logic [63:0] clint_time_t;

    function automatic logic [15:0] msip_addr(input int h);
        return CLINT_MSIP_BASE + 16'(4 * h);
    endfunction

    function automatic logic [15:0] cmp_lo_addr(input int h);
        return CLINT_MTIMECMP_BASE + 16'(8 * h);
    endfunction

    function automatic logic [15:0] cmp_hi_addr(input int h);
        return CLINT_MTIMECMP_BASE + 16'(8 * h + 4);
    endfunction

endpackage

// File: rtl/clint_prescaler.sv
// -----------------------------------------------------------------------------
// clint_prescaler
// Tick divider for mtime: the counter runs 0..div and asserts tick while it
// equals div, so mtime advances once every (div+1) clock cycles.
// Ports:
//   CLK     system clock
//   RST_N   synchronous active-low reset
//   div     divisor register value
//   div_wr  divisor being written this cycle; restarts the count
//   tick    mtime increment enable for this cycle
// -----------------------------------------------------------------------------
module clint_prescaler #(
    parameter int unsigned PRESC_W = 8
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [PRESC_W-1:0] div,
    input  logic               div_wr,
    output logic               tick
);

    logic [PRESC_W-1:0] cnt;

    assign tick = (cnt == div);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cnt <= '0;
        end else if (div_wr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PRESC_W'(1);
        end
    end

endmodule

// File: rtl/clint_timer.sv
// -----------------------------------------------------------------------------
// clint_timer
// Multi-hart machine timer: one shared 64-bit mtime with a programmable tick
// prescaler, one 64-bit mtimecmp per hart, registered per-hart timer IRQs and
// a 32-bit register port with a one-cycle registered response.
// Optional feature macro: CLINT_MSIP_EN (per-hart msip registers driving
// soft_int; without it the msip window reads 0 and soft_int is tied low).
// Ports:
//   CLK, RST_N        clock, synchronous active-low reset
//   req, we           access request (one access per asserted cycle), write
//   addr, wdata       byte address (addr[1:0] ignored), write data
//   rdata, ack        read data and completion, one cycle after req
//   mtime_h, mtime_l  current mtime halves
//   timer_int         bit h = (mtime >= mtimecmp[h])
//   soft_int          per-hart msip
// -----------------------------------------------------------------------------
module clint_timer
    import clint_pkg::*;
#(
    parameter int unsigned NUM_HARTS = 1,
    parameter int unsigned PRESC_W   = 8,
    parameter int unsigned PRESC_RST = 0
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 req,
    input  logic                 we,
    input  logic [15:0]          addr,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata,
    output logic                 ack,
    output logic [31:0]          mtime_h,
    output logic [31:0]          mtime_l,
    output logic [NUM_HARTS-1:0] timer_int,
    output logic [NUM_HARTS-1:0] soft_int
);

    logic [15:0]        addr_w;
    logic               unused_addr_bits;
    logic               wr;
    logic               div_wr;
    logic               tick;
    logic [PRESC_W-1:0] div;
    clint_time_t        mtime;
    clint_time_t        mtime_nxt;
    clint_time_t        cmp     [NUM_HARTS];
    clint_time_t        cmp_nxt [NUM_HARTS];
    logic [NUM_HARTS-1:0] ti_nxt;
    logic [31:0]        rd_nxt;

    assign addr_w           = {addr[15:2], 2'b00};
    assign unused_addr_bits = ^addr[1:0];
    assign wr               = req & we;
    assign div_wr           = wr && (addr_w == CLINT_DIV_ADDR);
    assign mtime_h          = mtime[63:32];
    assign mtime_l          = mtime[31:0];

    clint_prescaler #(.PRESC_W(PRESC_W)) u_presc (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .div    (div),
        .div_wr (div_wr),
        .tick   (tick)
    );

`ifdef CLINT_MSIP_EN
    logic [NUM_HARTS-1:0] msip;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            msip <= '0;
        end else begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                if (wr && (addr_w == msip_addr(h))) msip[h] <= wdata[0];
            end
        end
    end

    assign soft_int = msip;
`else
    assign soft_int = '0;
`endif

    // A register write takes priority over a tick landing in the same cycle.
    always_comb begin
        mtime_nxt = mtime;
        if (wr && (addr_w == CLINT_MTIME_LO)) begin
            mtime_nxt[31:0] = wdata;
        end else if (wr && (addr_w == CLINT_MTIME_HI)) begin
            mtime_nxt[63:32] = wdata;
        end else if (tick) begin
            mtime_nxt = mtime + 64'd1;
        end
    end

    // The IRQ compare uses next-state values so it lines up with the edge
    // that updates mtime/mtimecmp.
    always_comb begin
        ti_nxt = '0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            cmp_nxt[h] = cmp[h];
            if (wr && (addr_w == cmp_lo_addr(h))) cmp_nxt[h][31:0]  = wdata;
            if (wr && (addr_w == cmp_hi_addr(h))) cmp_nxt[h][63:32] = wdata;
            ti_nxt[h] = (mtime_nxt >= cmp_nxt[h]);
        end
    end

    always_comb begin
        rd_nxt = '0;
        if (addr_w == CLINT_DIV_ADDR) rd_nxt = 32'(div);
        if (addr_w == CLINT_MTIME_LO) rd_nxt = mtime[31:0];
        if (addr_w == CLINT_MTIME_HI) rd_nxt = mtime[63:32];
        for (int h = 0; h < NUM_HARTS; h++) begin
            if (addr_w == cmp_lo_addr(h)) rd_nxt = cmp[h][31:0];
            if (addr_w == cmp_hi_addr(h)) rd_nxt = cmp[h][63:32];
`ifdef CLINT_MSIP_EN
            if (addr_w == msip_addr(h)) rd_nxt = {31'b0, msip[h]};
`endif
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            mtime     <= '0;
            div       <= PRESC_W'(PRESC_RST);
            ack       <= 1'b0;
            rdata     <= '0;
            timer_int <= '0;
            for (int h = 0; h < NUM_HARTS; h++) cmp[h] <= '1;
        end else begin
            mtime     <= mtime_nxt;
            timer_int <= ti_nxt;
            ack       <= req;
            if (req) rdata <= rd_nxt;
            if (div_wr) div <= wdata[PRESC_W-1:0];
            for (int h = 0; h < NUM_HARTS; h++) cmp[h] <= cmp_nxt[h];
        end
    end

endmodule

// File: tb/tb_clint_timer.sv
// -----------------------------------------------------------------------------
// tb_clint_timer
// Directed bench for clint_timer with two harts. Each register access pushes
// its expected ack cycle and (for reads) expected rdata into a scoreboard; a
// monitor on the falling edge pops an entry whenever ack is high. Timer state
// (mtime, timer_int, soft_int) is checked directly against hand-computed
// values between accesses.
// -----------------------------------------------------------------------------
module tb_clint_timer;

    localparam int NH = 2;

`ifdef CLINT_MSIP_EN
    localparam logic [NH-1:0] SOFT_EXP  = 2'b10;
    localparam logic [31:0]   MSIP1_EXP = 32'h1;
`else
    localparam logic [NH-1:0] SOFT_EXP  = 2'b00;
    localparam logic [31:0]   MSIP1_EXP = 32'h0;
`endif

    logic          CLK   = 1'b0;
    logic          RST_N = 1'b0;
    logic          req   = 1'b0;
    logic          we    = 1'b0;
    logic [15:0]   addr  = '0;
    logic [31:0]   wdata = '0;
    logic [31:0]   rdata;
    logic          ack;
    logic [31:0]   mtime_h;
    logic [31:0]   mtime_l;
    logic [NH-1:0] timer_int;
    logic [NH-1:0] soft_int;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    typedef struct {
        logic [15:0] a;
        logic [31:0] d;
        logic        chk;
        int          c;
    } exp_t;

    exp_t sb [$];
    exp_t mon_e;

    always #5 CLK = ~CLK;

    clint_timer #(.NUM_HARTS(NH), .PRESC_W(8), .PRESC_RST(0)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .ack       (ack),
        .mtime_h   (mtime_h),
        .mtime_l   (mtime_l),
        .timer_int (timer_int),
        .soft_int  (soft_int)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    // Monitor: count falling edges, pop one expectation per ack.
    always @(negedge CLK) begin
        cyc = cyc + 1;
        if (ack) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL spurious_ack: ack=1 rdata=%h at cycle %0d, expected no ack", rdata, cyc);
            end else begin
                mon_e = sb.pop_front();
                check($sformatf("ack_cycle_%h", mon_e.a), 64'(cyc), 64'(mon_e.c));
                if (mon_e.chk) check($sformatf("rdata_%h", mon_e.a), {32'b0, rdata}, {32'b0, mon_e.d});
            end
        end else if (sb.size() != 0 && sb[0].c <= cyc) begin
            mon_e = sb.pop_front();
            n_checks++;
            $display("FAIL missing_ack_%h: ack=0 at cycle %0d, expected ack=1", mon_e.a, cyc);
        end
    end

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        req = 1'b0;
        we  = 1'b0;
        repeat (n) step();
    endtask

    task automatic rd(input logic [15:0] a, input logic [31:0] exp);
        req = 1'b1; we = 1'b0; addr = a; wdata = '0;
        sb.push_back('{a, exp, 1'b1, cyc + 1});
        step();
        req = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d);
        req = 1'b1; we = 1'b1; addr = a; wdata = d;
        sb.push_back('{a, 32'h0, 1'b0, cyc + 1});
        step();
        req = 1'b0; we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        RST_N = 1'b0;
        repeat (2) step();
        check("rst_mtime_l", 64'(mtime_l), 64'h0);
        check("rst_mtime_h", 64'(mtime_h), 64'h0);
        check("rst_timer_int", 64'(timer_int), 64'h0);
        check("rst_soft_int", 64'(soft_int), 64'h0);
        check("rst_ack", 64'(ack), 64'h0);
        RST_N = 1'b1;

        // div=0: one tick per cycle
        idle(10);
        check("free_run_mtime_l", 64'(mtime_l), 64'd10);
        check("free_run_timer_int", 64'(timer_int), 64'h0);
        check("free_run_rdata", 64'(rdata), 64'h0);
        check("free_run_ack", 64'(ack), 64'h0);

        // Back-to-back reads
        rd(16'h4000, 32'hFFFF_FFFF);
        rd(16'h4004, 32'hFFFF_FFFF);
        rd(16'h1234, 32'h0);
        idle(1);
        check("b2b_ack_low_after", 64'(ack), 64'h0);
        check("b2b_mtime_l", 64'(mtime_l), 64'd14);

        // mtimecmp[1] = 20
        wr(16'h4008, 32'd20);
        wr(16'h400C, 32'd0);
        check("cmp1_mtime_l", 64'(mtime_l), 64'd16);
        check("cmp1_ti_before", 64'(timer_int), 64'h0);
        idle(3);
        check("cmp1_ti_at19", 64'(timer_int), 64'h0);
        idle(1);
        check("cmp1_mtime_at20", 64'(mtime_l), 64'd20);
        check("cmp1_ti_at20", 64'(timer_int), 64'b10);
        idle(1);
        check("cmp1_ti_level", 64'(timer_int), 64'b10);
        rd(16'h4008, 32'd20);
        rd(16'h400C, 32'd0);
        wr(16'h400C, 32'd1);
        check("cmp1_ti_cleared", 64'(timer_int), 64'h0);

        // Prescaler div=3 and mtime writes
        wr(16'hBFF0, 32'd3);
        wr(16'hBFF8, 32'hFFFF_FFFC);
        wr(16'hBFFC, 32'h0);
        idle(1);
        check("div3_e3_l", 64'(mtime_l), 64'hFFFF_FFFC);
        check("div3_e3_h", 64'(mtime_h), 64'h0);
        idle(1);
        check("div3_e4_l", 64'(mtime_l), 64'hFFFF_FFFD);
        idle(3);
        check("div3_e7_l", 64'(mtime_l), 64'hFFFF_FFFD);
        idle(1);
        check("div3_e8_l", 64'(mtime_l), 64'hFFFF_FFFE);
        idle(8);
        check("carry_l", 64'(mtime_l), 64'h0);
        check("carry_h", 64'(mtime_h), 64'h1);

        // mtimecmp[0] = 0, then wrap mtime through 2^64-1
        wr(16'h4000, 32'h0);
        wr(16'h4004, 32'h0);
        check("cmp0_zero_ti", 64'(timer_int), 64'b01);
        wr(16'hBFF8, 32'hFFFF_FFFF);
        wr(16'hBFFC, 32'hFFFF_FFFF);
        check("max_mtime", {mtime_h, mtime_l}, 64'hFFFF_FFFF_FFFF_FFFF);
        check("max_ti", 64'(timer_int), 64'b11);
        idle(3);
        check("max_hold", {mtime_h, mtime_l}, 64'hFFFF_FFFF_FFFF_FFFF);
        idle(1);
        check("wrap_mtime", {mtime_h, mtime_l}, 64'h0);
        check("wrap_ti", 64'(timer_int), 64'b01);

        // mtime write in a tick cycle wins over the increment
        idle(3);
        wr(16'hBFF8, 32'h100);
        check("wr_wins_mtime", {mtime_h, mtime_l}, 64'h100);
        idle(4);
        check("after_wr_tick", 64'(mtime_l), 64'h101);
        rd(16'hBFF8, 32'h101);
        rd(16'hBFFC, 32'h0);
        rd(16'hBFF0, 32'd3);

        // Hart index beyond NUM_HARTS is unmapped
        wr(16'h4010, 32'hFFFF_FFFF);
        rd(16'h4010, 32'h0);
        check("unmapped_ti", 64'(timer_int), 64'b01);

        // msip window
        wr(16'h0004, 32'h1);
        check("soft_int", 64'(soft_int), 64'(SOFT_EXP));
        rd(16'h0004, MSIP1_EXP);
        rd(16'h0000, 32'h0);

        // Reset during an access drops it
        req = 1'b1; we = 1'b0; addr = 16'hBFF8; RST_N = 1'b0;
        step();
        req = 1'b0;
        check("rst_mid_ack", 64'(ack), 64'h0);
        check("rst_mid_rdata", 64'(rdata), 64'h0);
        check("rst_mid_mtime", {mtime_h, mtime_l}, 64'h0);
        check("rst_mid_ti", 64'(timer_int), 64'h0);
        check("rst_mid_soft", 64'(soft_int), 64'h0);
        RST_N = 1'b1;
        idle(1);
        check("post_rst_mtime", 64'(mtime_l), 64'd1);
        rd(16'hBFF0, 32'd0);
        rd(16'h400C, 32'hFFFF_FFFF);

        idle(2);
        check("scoreboard_drained", 64'(sb.size()), 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
